// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: processor port, tag/data array port and RAM port of the cache controller
interface cache_ctrl_if #(parameter int CNT_W = 16);
   logic             cpu_req, cpu_we, cpu_ready, busy;
   logic [31:0]      cpu_addr, cpu_wdata, cpu_rdata;
   logic             arr_rd_en, arr_wr_en, arr_wr_valid;
   logic [7:0]       arr_index;
   logic [87:0]      arr_rd_tag;
   logic [3:0]       arr_rd_valid;
   logic [127:0]     arr_rd_data;
   logic [1:0]       arr_wr_way;
   logic [21:0]      arr_wr_tag;
   logic [31:0]      arr_wr_data;
   logic             mem_req, mem_we, mem_ack;
   logic [31:0]      mem_addr, mem_wdata, mem_rdata;
   logic [CNT_W-1:0] hit_count, miss_count;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, arr_rd_tag, arr_rd_valid, arr_rd_data, mem_ack, mem_rdata,
      output cpu_ready, cpu_rdata, busy, arr_rd_en, arr_index, arr_wr_en, arr_wr_way, arr_wr_tag,
             arr_wr_data, arr_wr_valid, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, arr_rd_tag, arr_rd_valid, arr_rd_data, mem_ack, mem_rdata,
      input  cpu_ready, cpu_rdata, busy, arr_rd_en, arr_index, arr_wr_en, arr_wr_way, arr_wr_tag,
             arr_wr_data, arr_wr_valid, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
   );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: 4-way write-through cache sequencer with pseudo-LRU refill and hit/miss statistics
module cache_ctrl_fsm #(
   parameter int INIT_SETS = 256,
   parameter int CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   cache_ctrl_if.slave bus
);
   localparam logic [2:0] INIT = 3'd0, IDLE = 3'd1, COMPARE = 3'd2, MEM_WRITE = 3'd3, MEM_READ = 3'd4, FILL = 3'd5;
   localparam logic [9:0] INIT_LAST = 10'(4 * INIT_SETS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [2:0]  state;
   logic [9:0]  init_cnt;
   logic [31:0] req_addr, req_wdata, word, hit_data;
   logic        req_we, hit, has_free, accept, plru_we;
   logic [1:0]  victim, hit_way, free_way, plru_victim, acc_way;
   logic [7:0]  idx;
   logic [2:0]  plru [0:255];
   logic [2:0]  cur_plru, upd_plru;
   assign idx         = req_addr[9:2];
   assign accept      = state == IDLE && bus.cpu_req && !bus.cpu_ready;
   assign cur_plru    = plru[idx];
   assign plru_victim = {cur_plru[0], cur_plru[0] ? cur_plru[2] : cur_plru[1]};
   assign acc_way     = state == FILL ? victim : hit_way;
   assign upd_plru    = acc_way[1] ? {~acc_way[0], cur_plru[1], 1'b0} : {cur_plru[2], ~acc_way[0], 1'b1};
   assign plru_we     = (state == COMPARE && hit) || state == FILL;
   assign hit_data    = bus.arr_rd_data[32*hit_way +: 32];
   assign bus.busy         = state != IDLE;
   assign bus.arr_rd_en    = accept;
   assign bus.arr_index    = state == INIT ? init_cnt[9:2] : state == IDLE ? bus.cpu_addr[9:2] : idx;
   assign bus.arr_wr_en    = state == INIT || state == FILL || (state == COMPARE && req_we && hit);
   assign bus.arr_wr_way   = state == INIT ? init_cnt[1:0] : state == FILL ? victim : hit_way;
   assign bus.arr_wr_tag   = req_addr[31:10];
   assign bus.arr_wr_data  = state == FILL ? word : req_wdata;
   assign bus.arr_wr_valid = state != INIT;
   assign bus.mem_req      = state == MEM_WRITE || state == MEM_READ;
   assign bus.mem_we       = state == MEM_WRITE;
   assign bus.mem_addr     = bus.mem_req ? req_addr : '0;
   assign bus.mem_wdata    = bus.mem_we ? req_wdata : '0;
   // tag match (lowest way wins) and lowest invalid way, from the array read returned in COMPARE
   always_comb begin
      hit      = 1'b0;
      hit_way  = 2'd0;
      has_free = 1'b0;
      free_way = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (bus.arr_rd_valid[w] && bus.arr_rd_tag[22*w +: 22] == req_addr[31:10]) begin
            hit     = 1'b1;
            hit_way = 2'(w);
         end
         if (!bus.arr_rd_valid[w]) begin
            has_free = 1'b1;
            free_way = 2'(w);
         end
      end
   end
   // sequencing FSM, request latches, processor response and saturating statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= INIT;
         init_cnt       <= '0;
         req_addr       <= '0;
         req_we         <= 1'b0;
         req_wdata      <= '0;
         victim         <= '0;
         word           <= '0;
         bus.cpu_ready  <= 1'b0;
         bus.cpu_rdata  <= '0;
         bus.hit_count  <= '0;
         bus.miss_count <= '0;
      end else begin
         bus.cpu_ready <= 1'b0;
         case (state)
            INIT: begin
               init_cnt <= init_cnt + 10'd1;
               if (init_cnt == INIT_LAST) state <= IDLE;
            end
            IDLE: if (accept) begin
               req_addr  <= bus.cpu_addr;
               req_we    <= bus.cpu_we;
               req_wdata <= bus.cpu_wdata;
               state     <= COMPARE;
            end
            COMPARE: begin
               if (hit && bus.hit_count != CNT_MAX) bus.hit_count <= bus.hit_count + 1'b1;
               if (!hit && bus.miss_count != CNT_MAX) bus.miss_count <= bus.miss_count + 1'b1;
               if (req_we) state <= MEM_WRITE;
               else if (hit) begin
                  bus.cpu_rdata <= hit_data;
                  bus.cpu_ready <= 1'b1;
                  state         <= IDLE;
               end else begin
                  victim <= has_free ? free_way : plru_victim;
                  state  <= MEM_READ;
               end
            end
            MEM_WRITE: if (bus.mem_ack) begin
               bus.cpu_ready <= 1'b1;
               state         <= IDLE;
            end
            MEM_READ: if (bus.mem_ack) begin
               word  <= bus.mem_rdata;
               state <= FILL;
            end
            FILL: begin
               bus.cpu_rdata <= word;
               bus.cpu_ready <= 1'b1;
               state         <= IDLE;
            end
            default: state <= INIT;
         endcase
      end
   end
   // pseudo-LRU bits per set, cleared by reset and touched on every hit or fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < 256; i++) plru[i] <= '0;
      else if (plru_we) plru[idx] <= upd_plru;
   end
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: directed checks of init sweep, hits, misses, PLRU refill, write-through and reset abort
module tb_cache_ctrl_fsm;
   logic clk = 1'b0, rst_n = 1'b0;
   int n_checks = 0, n_fail = 0;
   cache_ctrl_if #(.CNT_W(4)) bus();
   cache_ctrl_fsm #(.INIT_SETS(256), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   logic [21:0] tag_m   [0:255][0:3];
   logic [31:0] data_m  [0:255][0:3];
   logic        valid_m [0:255][0:3];
   int ram_delay = 0, wait_cnt = 0, init_k = 0, init_bad = 0, wr_valid_cnt = 0;
   logic [31:0] ram_word = 0, last_waddr = 0, last_wdata = 0;
   logic [1:0]  last_fill_way = 0;
   logic        force_ack = 1'b0, init_phase = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // synchronous tag/data/valid array and observation of array and RAM writes
   always @(posedge clk) begin
      if (bus.arr_rd_en)
         for (int w = 0; w < 4; w++) begin
            bus.arr_rd_tag[22*w +: 22]  <= tag_m[bus.arr_index][w];
            bus.arr_rd_data[32*w +: 32] <= data_m[bus.arr_index][w];
            bus.arr_rd_valid[w]         <= valid_m[bus.arr_index][w];
         end
      if (bus.arr_wr_en) begin
         tag_m[bus.arr_index][bus.arr_wr_way]   <= bus.arr_wr_tag;
         data_m[bus.arr_index][bus.arr_wr_way]  <= bus.arr_wr_data;
         valid_m[bus.arr_index][bus.arr_wr_way] <= bus.arr_wr_valid;
      end
      if (rst_n && bus.arr_wr_en && init_phase) begin
         if (bus.arr_index != 8'(init_k >> 2) || bus.arr_wr_way != 2'(init_k) || bus.arr_wr_valid) init_bad++;
         init_k++;
      end
      if (rst_n && bus.arr_wr_en && bus.arr_wr_valid) begin
         wr_valid_cnt++;
         last_fill_way <= bus.arr_wr_way;
      end
      if (rst_n && bus.mem_req && bus.mem_ack && bus.mem_we) begin
         last_waddr <= bus.mem_addr;
         last_wdata <= bus.mem_wdata;
      end
   end

   // RAM responder: acks ram_delay cycles after mem_req rises, or whenever force_ack is set
   always @(negedge clk) begin
      bus.mem_ack = force_ack;
      if (force_ack) bus.mem_rdata = 32'd999;
      if (!rst_n || !bus.mem_req) wait_cnt = 0;
      else if (wait_cnt >= ram_delay) begin
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = ram_word;
         wait_cnt      = 0;
      end else wait_cnt++;
   end

   task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata);
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      lat   = -1;
      rdata = '0;
      for (int c = 1; c <= 60 && lat < 0; c++) begin
         @(negedge clk);
         if (bus.cpu_ready) begin
            lat   = c;
            rdata = bus.cpu_rdata;
         end
      end
      bus.cpu_req = 1'b0;
   endtask

   initial begin
      int lat, c, ready_seen;
      logic [31:0] rdv;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 1);
      check("rst_ready", bus.cpu_ready, 0);
      check("rst_rdata", bus.cpu_rdata, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_rd_en", bus.arr_rd_en, 0);
      check("rst_hits", bus.hit_count, 0);
      check("rst_misses", bus.miss_count, 0);
      rst_n = 1'b1;
      repeat (1023) @(negedge clk);
      check("init_busy_1023", bus.busy, 1);
      @(negedge clk);
      check("init_busy_1024", bus.busy, 0);
      check("init_writes", init_k, 1024);
      check("init_pattern", init_bad, 0);
      check("idle_no_wr", bus.arr_wr_en, 0);
      init_phase = 1'b0;
      // first read misses and fills way 0, the repeat hits
      ram_delay = 3;
      ram_word  = 500;
      cpu_op(1'b0, 32'h14, 0, lat, rdv);
      check("miss_lat", lat, 7);
      check("miss_data", rdv, 500);
      check("miss_cnt", bus.miss_count, 1);
      check("fill_tag", tag_m[5][0], 0);
      check("fill_valid", valid_m[5][0], 1);
      check("fill_word", data_m[5][0], 500);
      cpu_op(1'b0, 32'h14, 0, lat, rdv);
      check("hit_lat", lat, 2);
      check("hit_data", rdv, 500);
      check("hit_cnt", bus.hit_count, 1);
      // five misses to one set: invalid ways first, then PLRU evicts way 0
      for (int t = 1; t <= 5; t++) begin
         ram_word = 100 + t;
         cpu_op(1'b0, (t << 10) | 32'h1c, 0, lat, rdv);
         check("set_fill_data", rdv, 100 + t);
         check("set_fill_way", last_fill_way, (t - 1) % 4);
      end
      check("evict_tag", tag_m[7][0], 5);
      check("set_miss_cnt", bus.miss_count, 6);
      cpu_op(1'b0, 32'h81c, 0, lat, rdv);
      check("way1_hit_lat", lat, 2);
      check("way1_hit_data", rdv, 102);
      ram_word = 201;
      cpu_op(1'b0, 32'h41c, 0, lat, rdv);
      check("refill_lat", lat, 7);
      check("refill_way", last_fill_way, 2);
      check("refill_data", rdv, 201);
      check("refill_miss_cnt", bus.miss_count, 7);
      // write hit updates the array and writes through
      ram_delay = 1;
      cpu_op(1'b1, 32'h14, 10, lat, rdv);
      check("wr_hit_lat", lat, 4);
      check("wr_hit_array", data_m[5][0], 10);
      check("wr_hit_way", last_fill_way, 0);
      check("wr_hit_maddr", last_waddr, 32'h14);
      check("wr_hit_mdata", last_wdata, 10);
      check("wr_hit_cnt", bus.hit_count, 3);
      cpu_op(1'b0, 32'h14, 0, lat, rdv);
      check("after_wr_lat", lat, 2);
      check("after_wr_data", rdv, 10);
      // write miss with zero-wait RAM: no allocation
      ram_delay = 0;
      c = wr_valid_cnt;
      cpu_op(1'b1, 32'h400, 77, lat, rdv);
      check("wr_miss_lat", lat, 3);
      check("wr_miss_no_alloc", wr_valid_cnt, c);
      check("wr_miss_maddr", last_waddr, 32'h400);
      check("wr_miss_mdata", last_wdata, 77);
      check("wr_miss_cnt", bus.miss_count, 8);
      check("wr_miss_hits", bus.hit_count, 4);
      ram_word = 33;
      cpu_op(1'b0, 32'h400, 0, lat, rdv);
      check("zw_miss_lat", lat, 4);
      check("zw_miss_data", rdv, 33);
      check("zw_miss_cnt", bus.miss_count, 9);
      // hit counter saturates at 15 with a 4-bit counter
      for (int i = 0; i < 12; i++) cpu_op(1'b0, 32'h14, 0, lat, rdv);
      check("sat_hits", bus.hit_count, 15);
      check("sat_misses", bus.miss_count, 9);
      // reset while waiting on RAM read, then a late ack during INIT
      ram_delay = 1000;
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h800;
      repeat (2) @(negedge clk);
      check("mr_mem_req", bus.mem_req, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_mem_req", bus.mem_req, 0);
      check("abort_mem_addr", bus.mem_addr, 0);
      check("abort_busy", bus.busy, 1);
      check("abort_hits", bus.hit_count, 0);
      check("abort_misses", bus.miss_count, 0);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      force_ack = 1'b1;
      repeat (3) @(negedge clk);
      force_ack  = 1'b0;
      c          = 0;
      ready_seen = 0;
      while (bus.busy && c < 1100) begin
         @(negedge clk);
         c++;
         if (bus.cpu_ready) ready_seen++;
      end
      check("reinit_done", bus.busy, 0);
      check("late_ack_ignored", ready_seen, 0);
      check("reinit_misses", bus.miss_count, 0);
      ram_delay = 0;
      ram_word  = 55;
      cpu_op(1'b0, 32'h14, 0, lat, rdv);
      check("post_reset_miss_lat", lat, 4);
      check("post_reset_data", rdv, 55);
      check("post_reset_miss_cnt", bus.miss_count, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
